// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
// Clear-engine state encoding lives here so the top and controller agree.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

endpackage

// File: rtl/regfile_clr_ctrl.sv
// Sequential bulk-clear engine: walks every writable register and zeroes it.
// Latency: one register per cycle, then a single-cycle done pulse.
// Backpressure: none; requests while busy are dropped, not queued.
module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_busy,
  output logic                  clr_done
);

  // Register 0 never holds data under ZERO_REG, so the sweep skips it.
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

  clr_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = FIRST_ADDR;
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        if (cnt == LAST_ADDR) state_nxt = ST_DONE;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      ST_DONE: begin
        clr_busy  = 1'b1;
        clr_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file; REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
// Latency: reads combinational, writes visible next cycle; clear takes one cycle per register.
// Backpressure: WB writes are dropped while clr_busy is high; upstream must stall on it.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NREAD      = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  input  logic                        clr_req,
  output logic                        clr_busy,
  output logic                        clr_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wb_wr;

  regfile_clr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  // A WB write only lands when the clear engine is idle and the target is writable.
  assign wb_wr = we && !clr_busy && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wb_wr) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (wb_wr && (waddr == ra)) rd = wdata;
`endif
      if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic           clr_req;
  logic           clr_busy;
  logic           clr_done;

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;   // 0..NR-1 read port, 8 = clr_busy, 9 = clr_done
    logic [31:0] exp;
    string       tag;
  } chk_t;

  chk_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model: register contents plus an abstract clear progress marker.
  logic [31:0] model [32];
  int          clr_pos;      // next register to zero, -1 when no sweep in progress
  bit          done_pend;    // sweep finished, done pulse still to be shown
  int          busy_seen, done_seen;

  function automatic bit m_busy();
    return (clr_pos >= 0) || done_pend;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && !m_busy() && waddr != 0 && int'(waddr) == a) return wdata;
`endif
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    clr_pos   = -1;
    done_pend = 1'b0;
  endtask

  task automatic push_all();
    chk_t c;
    for (int k = 0; k < NR; k++) begin
      c.sel = k;
      c.exp = exp_rd(int'(raddr[k*AW +: AW]));
      c.tag = $sformatf("rdata%0d[r%0d]", k, raddr[k*AW +: AW]);
      sb.push_back(c);
    end
    c.sel = 8; c.exp = {31'h0, m_busy()};  c.tag = "clr_busy"; sb.push_back(c);
    c.sel = 9; c.exp = {31'h0, done_pend}; c.tag = "clr_done"; sb.push_back(c);
  endtask

  // Model advance for one rising edge, written from the behavioural rules.
  task automatic model_edge(input bit w, input int wa, input logic [31:0] wd, input bit cr);
    if (clr_pos >= 0) begin
      model[clr_pos] = 32'h0;
      if (clr_pos == 31) begin
        clr_pos   = -1;
        done_pend = 1'b1;
      end else begin
        clr_pos++;
      end
    end else if (done_pend) begin
      done_pend = 1'b0;
    end else begin
      if (w && wa != 0) model[wa] = wd;
      if (cr) clr_pos = 1;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic step(input bit w, input int wa, input logic [31:0] wd,
                      input int a0, input int a1, input bit cr);
    we      = w;
    waddr   = AW'(wa);
    wdata   = wd;
    raddr   = {AW'(a1), AW'(a0)};
    clr_req = cr;
    if (clr_busy) busy_seen++;
    if (clr_done) done_seen++;
    push_all();
    @(posedge clk);
    model_edge(w, wa, wd, cr);
    #1;
  endtask

  // Async reset asserted between edges; outputs are checked before any rising edge.
  task automatic do_reset(input int a0, input int a1);
    we      = 1'b0;
    clr_req = 1'b0;
    raddr   = {AW'(a1), AW'(a0)};
    rst_n   = 1'b0;
    model_reset();
    push_all();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, expv);
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) step(1'b0, 0, 32'h0, 2*i, 2*i + 1, 1'b0);
  endtask

  // Monitor: outputs are always presented, so every pending expectation is settled at negedge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c = sb.pop_front();
      if (c.sel < NR)      act = rdata[c.sel*DW +: DW];
      else if (c.sel == 8) act = {31'h0, clr_busy};
      else                 act = {31'h0, clr_done};
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h at %0t", c.tag, act, c.exp, $time);
      end
    end
  end

  initial begin
    we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
    busy_seen = 0; done_seen = 0;
    rst_n = 1'b0;
    raddr = {AW'(9), AW'(5)};
    model_reset();
    push_all();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write, read back, then async reset mid-run clears it.
    step(1'b1, 5, 32'hDEADBEEF, 5, 5, 1'b0);
    step(1'b0, 0, 32'h0, 5, 5, 1'b0);
    do_reset(5, 5);

    // Both ports on the same register; register 0 ignores writes.
    step(1'b1, 7, 32'h12345678, 0, 0, 1'b0);
    step(1'b0, 0, 32'h0, 7, 7, 1'b0);
    step(1'b1, 0, 32'hFFFFFFFF, 0, 7, 1'b0);
    step(1'b0, 0, 32'h0, 0, 0, 1'b0);

    // Same-cycle write/read: forwarded only with bypass built in.
    step(1'b1, 3, 32'hA5A5A5A5, 3, 3, 1'b0);
    step(1'b0, 0, 32'h0, 3, 0, 1'b0);

    // Random traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           $urandom_range(0, 59) == 0);
    end
    repeat (40) step(1'b0, 0, 32'h0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);

    // Full clear after filling every register with its index.
    for (int i = 1; i < 32; i++) step(1'b1, i, 32'(i), i, i - 1, 1'b0);
    busy_seen = 0; done_seen = 0;
    step(1'b0, 0, 32'h0, 1, 31, 1'b1);
    repeat (40) step(1'b0, 0, 32'h0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);
    check_cnt("full_clear_busy_len", busy_seen, 32);
    check_cnt("full_clear_done_cnt", done_seen, 1);
    sweep();

    // Write and second request issued mid-clear are both dropped.
    for (int i = 1; i < 32; i++) step(1'b1, i, $urandom, 0, i, 1'b0);
    busy_seen = 0; done_seen = 0;
    step(1'b0, 0, 32'h0, 31, 30, 1'b1);
    repeat (5) step(1'b0, 0, 32'h0, 31, 6, 1'b0);
    step(1'b1, 31, 32'h55, 31, 31, 1'b1);
    repeat (50) step(1'b0, 0, 32'h0, 31, int'($urandom_range(0, 31)), 1'b0);
    check_cnt("rereq_busy_len", busy_seen, 32);
    check_cnt("rereq_done_cnt", done_seen, 1);

    // Reset after ten sweep cycles aborts with no done pulse.
    for (int i = 1; i < 32; i++) step(1'b1, i, $urandom | 32'h1, i, 0, 1'b0);
    busy_seen = 0; done_seen = 0;
    step(1'b0, 0, 32'h0, 20, 30, 1'b1);
    repeat (10) step(1'b0, 0, 32'h0, 20, 30, 1'b0);
    do_reset(20, 30);
    busy_seen = 0; done_seen = 0;
    repeat (5) step(1'b0, 0, 32'h0, 25, 31, 1'b0);
    check_cnt("abort_no_done", done_seen, 0);
    check_cnt("abort_busy_low", busy_seen, 0);
    sweep();
    for (int i = 1; i < 32; i++) step(1'b1, i, 32'hC0DE0000 | 32'(i), 0, i, 1'b0);
    busy_seen = 0; done_seen = 0;
    step(1'b0, 0, 32'h0, 4, 8, 1'b1);
    repeat (40) step(1'b0, 0, 32'h0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0);
    check_cnt("post_abort_busy_len", busy_seen, 32);
    check_cnt("post_abort_done_cnt", done_seen, 1);
    sweep();

    @(negedge clk);
    @(negedge clk);
    check_cnt("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
